mgmt_multi_timer: RTL and testbench
===================================

// Module: mgmt_multi_timer
// PURPOSE
//  Parametrised multi-channel down-counting timer for the management SoC, next generation
//  of the single LiteX-style timer (load/reload/en/update_value/value/zero event).
//  Adds N channels, configurable width, per-channel prescaler, channel chaining and
//  per-channel IRQs.
//  Sits on the mgmt Wishbone bus as a slave; irq_o feeds the CPU interrupt controller.
// PARAMETERS
//  NUM_CH   4   number of timer channels (1..8)
//  WIDTH    32  counter width in bits (1..32); narrower registers read zero-extended
//  PRE_W    8   prescaler field width (1..16)
//  ADDR_W   8   byte-address bits decoded from wb_adr_i
// PORTS
//  core_clk   in   1             single system clock
//  core_rstn  in   1             asynchronous, active-low reset
//  wb_cyc_i   in   1             Wishbone cycle
//  wb_stb_i   in   1             Wishbone strobe
//  wb_we_i    in   1             write enable
//  wb_sel_i   in   4             byte enables
//  wb_adr_i   in   ADDR_W        byte address
//  wb_dat_i   in   32            write data
//  wb_dat_o   out  32            read data, registered
//  wb_ack_o   out  1             one-cycle acknowledge
//  irq_o      out  NUM_CH        per-channel interrupt = pending & IRQ_EN
// BEHAVIOUR
//  Reset: all registers, counters, prescalers, pending bits 0; wb_dat_o=0, wb_ack_o=0, irq_o=0.
//  Map: ch = adr[ADDR_W-1:5], reg = adr[4:2]; per-channel regs:
//   0x00 LOAD (RW)   0x04 RELOAD (RW)   0x08 CTRL (RW)   0x0C VALUE (RO snapshot)
//   0x10 UPDATE (WO, any write latches counter into snapshot)   0x14 STATUS (bit0 pending, W1C)
//  CTRL: [0] EN, [1] IRQ_EN, [2] CHAIN (ignored on ch0), [8 +: PRE_W] PRE.
//  Bus: ack asserted the cycle after cyc&stb&!ack, for exactly one cycle; no wait states.
//   Writes honour wb_sel_i on LOAD/RELOAD/CTRL. Unmapped reg or ch>=NUM_CH: read 0,
//   write ignored, still acked.
//  Tick: CHAIN=0 -> prescaler counts 0..PRE, tick on the PRE cycle (rate = clk/(PRE+1),
//   PRE=0 -> every cycle). CHAIN=1 -> tick = zero event of ch-1; own prescaler held at 0.
//  Counter, EN=0: value <= LOAD every cycle; prescaler cleared.
//  Counter, EN=1, on tick: value!=0 -> value-1; value==0 & RELOAD!=0 -> value <= RELOAD;
//   value==0 & RELOAD==0 -> hold 0 (one-shot). No tick -> hold.
//  Zero event: one-cycle pulse when a tick moves value 1->0; sets pending.
//   Pulse is also the chain tick for ch+1, seen the same cycle (combinational).
//  STATUS W1C same cycle as set -> set wins. Writing LOAD while EN=1 does not disturb count.
//  UPDATE in same cycle as tick -> snapshot captures pre-tick value.
//  EN 1->0 mid-count: next cycle value=LOAD; pending untouched.
//  Async reset mid-bus-cycle: ack dropped immediately; master must retry.
//  Arithmetic modulo 2^WIDTH; bus bits above WIDTH ignored on write, 0 on read.
// STRUCTURE
//  mgmt_timer_pkg: register offsets, CTRL bit positions, channel stride (0x20).
//  Sub-module mgmt_timer_channel: one counter + prescaler + pending + snapshot;
//   inputs: reg writes, chain_tick; outputs: value, zero pulse, pending.
//  Top: Wishbone decode/ack, read mux, chain wiring, irq gating (generate over NUM_CH).
// TESTING
//  1 Reset: core_rstn low mid-run -> all reads 0, irq_o=0, wb_ack_o low immediately.
//  2 One-shot: LOAD=0x10, RELOAD=0, PRE=0, EN=1 -> zero after 16 cycles, holds 0,
//    pending=1, irq_o[0]=1 only with IRQ_EN.
//  3 Periodic + prescale: LOAD=3, RELOAD=3, PRE=4 -> zero pulse every 20 cycles;
//    UPDATE/VALUE reads show 3,2,1,0,3 sequence.
//  4 Chain: ch0 LOAD=RELOAD=9 PRE=0; ch1 CHAIN=1 LOAD=RELOAD=4 -> ch1 zero every
//    50 cycles (5x10), ch1 decrements only on ch0 zero pulses.
//  5 W1C race: write STATUS=1 on the cycle of a zero event -> pending stays 1;
//    next W1C clears it.
//  6 Bus edges: WIDTH=16 build, write 0xFFFF_1234 to LOAD -> reads 0x0000_1234;
//    sel=4'b0001 write touches byte0 only; read ch=NUM_CH -> 0 with ack.

Source files
------------

// File: rtl/mgmt_timer_pkg.sv
// mgmt_timer_pkg: register map, CTRL bit positions and bus helpers shared by the multi-channel timer.
package mgmt_timer_pkg;

   localparam int CH_STRIDE = 32'h20;
   localparam int CH_SHIFT  = $clog2(CH_STRIDE);

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CHAIN  = 2;
   localparam int CTRL_PRE    = 8;

   typedef enum logic [2:0] {
      REG_LOAD   = 3'd0,
      REG_RELOAD = 3'd1,
      REG_CTRL   = 3'd2,
      REG_VALUE  = 3'd3,
      REG_UPDATE = 3'd4,
      REG_STATUS = 3'd5
   } reg_e;

   typedef struct packed {
      logic load;
      logic reload;
      logic ctrl;
      logic update;
      logic status;
   } reg_wr_t;

   function automatic logic [31:0] sel_merge(logic [31:0] old, logic [31:0] wdat, logic [3:0] sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/mgmt_multi_timer_if.sv
// mgmt_multi_timer_if: Wishbone classic slave bundle for the management timer.
interface mgmt_multi_timer_if #(parameter int ADDR_W = 8);

   logic              cyc;
   logic              stb;
   logic              we;
   logic [3:0]        sel;
   logic [ADDR_W-1:0] adr;
   logic [31:0]       dat_w;
   logic [31:0]       dat_r;
   logic              ack;

   modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);

endinterface

// File: rtl/mgmt_timer_channel.sv
// mgmt_timer_channel: one down-counter with prescaler, chain input, pending flag and value snapshot.
module mgmt_timer_channel
   import mgmt_timer_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int PRE_W    = 8,
   parameter bit CHAIN_OK = 1'b1
) (
   input  logic        core_clk,
   input  logic        core_rstn,
   input  reg_wr_t     wr,
   input  logic [31:0] wdat,
   input  logic [3:0]  wsel,
   input  logic        chain_tick,
   output logic [31:0] load,
   output logic [31:0] reload,
   output logic [31:0] ctrl,
   output logic [31:0] snap,
   output logic        zero,
   output logic        pending
);

   localparam logic [31:0] VAL_MASK  = 32'((64'd1 << WIDTH) - 64'd1);
   localparam logic [31:0] CTRL_MASK = 32'h7 | 32'(((64'd1 << PRE_W) - 64'd1) << CTRL_PRE);

   logic [WIDTH-1:0] value;
   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre;
   logic             en;
   logic             chain;
   logic             tick;

   assign en    = ctrl[CTRL_EN];
   assign chain = CHAIN_OK && ctrl[CTRL_CHAIN];
   assign pre   = ctrl[CTRL_PRE +: PRE_W];
   // >= rather than == so lowering PRE mid-count cannot strand the prescaler above it
   assign tick  = chain ? chain_tick : pre_cnt >= pre;
   assign zero  = en && tick && value == WIDTH'(1);

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         load    <= '0;
         reload  <= '0;
         ctrl    <= '0;
         snap    <= '0;
         value   <= '0;
         pre_cnt <= '0;
         pending <= 1'b0;
      end else begin
         if (wr.load)   load   <= sel_merge(load, wdat, wsel) & VAL_MASK;
         if (wr.reload) reload <= sel_merge(reload, wdat, wsel) & VAL_MASK;
         if (wr.ctrl)   ctrl   <= sel_merge(ctrl, wdat, wsel) & CTRL_MASK;
         if (wr.update) snap   <= 32'(value);
         pending <= zero | (pending & !(wr.status & wdat[0]));
         pre_cnt <= (!en || chain || tick) ? '0 : pre_cnt + PRE_W'(1);
         // reload of zero leaves the counter parked at zero (one-shot)
         value   <= !en ? load[WIDTH-1:0] : !tick ? value : value != '0 ? value - WIDTH'(1) : reload[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mgmt_multi_timer.sv
// mgmt_multi_timer: Wishbone-mapped bank of NUM_CH chainable down-counting timers with per-channel IRQs.
module mgmt_multi_timer
   import mgmt_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32,
   parameter int PRE_W  = 8,
   parameter int ADDR_W = 8
) (
   input  logic                 core_clk,
   input  logic                 core_rstn,
   mgmt_multi_timer_if.slave    wb,
   output logic [NUM_CH-1:0]    irq_o
);

   localparam int CH_W = ADDR_W - CH_SHIFT;

   logic            req;
   logic [CH_W-1:0] ch;
   reg_e            rsel;
   logic [31:0]     rd_vec [NUM_CH];
   logic [31:0]     rd_data;
   logic [NUM_CH:0] chain_v;
   logic            unused_bits;

   assign req         = wb.cyc && wb.stb && !wb.ack;
   assign ch          = wb.adr[ADDR_W-1:CH_SHIFT];
   assign rsel        = reg_e'(wb.adr[CH_SHIFT-1:2]);
   assign chain_v[0]  = 1'b0;
   assign unused_bits = ^{wb.adr[1:0], chain_v[NUM_CH]};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      reg_wr_t     wr;
      logic        hit;
      logic [31:0] load;
      logic [31:0] reload;
      logic [31:0] ctrl;
      logic [31:0] snap;
      logic        pending;

      assign hit = req && wb.we && ch == CH_W'(i);
      assign wr  = '{load:   hit && rsel == REG_LOAD,
                     reload: hit && rsel == REG_RELOAD,
                     ctrl:   hit && rsel == REG_CTRL,
                     update: hit && rsel == REG_UPDATE,
                     status: hit && rsel == REG_STATUS};

      mgmt_timer_channel #(
         .WIDTH   (WIDTH),
         .PRE_W   (PRE_W),
         .CHAIN_OK(i != 0)
      ) u_ch (
         .core_clk  (core_clk),
         .core_rstn (core_rstn),
         .wr        (wr),
         .wdat      (wb.dat_w),
         .wsel      (wb.sel),
         .chain_tick(chain_v[i]),
         .load      (load),
         .reload    (reload),
         .ctrl      (ctrl),
         .snap      (snap),
         .zero      (chain_v[i+1]),
         .pending   (pending)
      );

      assign rd_vec[i] = rsel == REG_LOAD   ? load   :
                         rsel == REG_RELOAD ? reload :
                         rsel == REG_CTRL   ? ctrl   :
                         rsel == REG_VALUE  ? snap   :
                         rsel == REG_STATUS ? {31'b0, pending} : '0;
      assign irq_o[i]  = pending && ctrl[CTRL_IRQ_EN];
   end

   // channels past NUM_CH match nothing and read as zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch == CH_W'(i)) rd_data = rd_vec[i];
   end

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         wb.ack   <= 1'b0;
         wb.dat_r <= '0;
      end else begin
         wb.ack   <= req;
         wb.dat_r <= req && !wb.we ? rd_data : '0;
      end
   end

endmodule

// File: tb/tb_mgmt_multi_timer.sv
// tb_mgmt_multi_timer: scoreboard bench for the multi-channel timer (WIDTH=16 build).
module tb_mgmt_multi_timer;

   logic        core_clk  = 1'b0;
   logic        core_rstn = 1'b0;
   logic [3:0]  irq_o;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   int          p;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   mgmt_multi_timer_if #(.ADDR_W(8)) wb ();

   mgmt_multi_timer #(
      .NUM_CH(4),
      .WIDTH (16),
      .PRE_W (8),
      .ADDR_W(8)
   ) dut (
      .core_clk (core_clk),
      .core_rstn(core_rstn),
      .wb       (wb),
      .irq_o    (irq_o)
   );

   always #5 core_clk = ~core_clk;
   always @(posedge core_clk) cyc_n <= cyc_n + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] a(int c, int r);
      return 8'(c * 32 + r * 4);
   endfunction

   task automatic bus(logic [7:0] adr, logic we, logic [31:0] d, logic [3:0] sel);
      @(posedge core_clk); #1;
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.dat_w = d; wb.sel = sel;
      for (int k = 0; k < 4; k++) begin
         @(posedge core_clk); #1;
         if (wb.ack) break;
      end
      check("ack", 32'(wb.ack), 32'd1);
      wb.cyc = 1'b0; wb.stb = 1'b0;
   endtask

   task automatic wr(logic [7:0] adr, logic [31:0] d, logic [3:0] sel = 4'hF);
      bus(adr, 1'b1, d, sel);
   endtask

   task automatic rd(string tag, logic [7:0] adr, logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      bus(adr, 1'b0, 32'd0, 4'h0);
      check(tag_q.pop_front(), wb.dat_r, exp_q.pop_front());
   endtask

   task automatic wait_to(int n);
      while (cyc_n < n) begin
         @(posedge core_clk); #1;
      end
   endtask

   task automatic wr_at(int n, logic [7:0] adr, logic [31:0] d);
      wait_to(n - 2);
      wr(adr, d);
   endtask

   task automatic snap_at(string tag, int n, int c, logic [31:0] exp);
      wr_at(n, a(c, 4), 32'd1);
      rd(tag, a(c, 3), exp);
   endtask

   initial begin
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 4'h0; wb.adr = '0; wb.dat_w = '0;
      repeat (3) @(posedge core_clk);
      #1;
      check("rst_ack", 32'(wb.ack), 32'd0);
      check("rst_dat", wb.dat_r, 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      core_rstn = 1'b1;
      rd("rst_ctrl0", a(0, 2), 32'd0);
      rd("rst_load1", a(1, 0), 32'd0);
      rd("rst_stat3", a(3, 5), 32'd0);

      // one-shot on ch0 with IRQ enabled
      wr(a(0, 0), 32'h10);
      wr(a(0, 1), 32'h0);
      wr(a(0, 2), 32'h3);
      p = cyc_n;
      wait_to(p + 15); check("os_irq_pre", 32'(irq_o), 32'h0);
      wait_to(p + 16); check("os_irq", 32'(irq_o), 32'h1);
      wait_to(p + 22);
      wr(a(0, 4), 32'd1);
      rd("os_hold0", a(0, 3), 32'd0);
      rd("os_pend", a(0, 5), 32'd1);
      wr(a(0, 2), 32'h1);
      #1 check("os_irq_gated", 32'(irq_o), 32'h0);
      wr(a(0, 5), 32'd1);
      rd("os_w1c", a(0, 5), 32'd0);
      wr(a(0, 2), 32'h0);

      // periodic with prescaler on ch2: PRE=4, LOAD=RELOAD=3
      wr(a(2, 0), 32'd3);
      wr(a(2, 1), 32'd3);
      wr(a(2, 2), 32'h403);
      p = cyc_n;
      wait_to(p + 14); check("per_irq_pre", 32'(irq_o), 32'h0);
      wait_to(p + 15); check("per_irq", 32'(irq_o), 32'h4);
      wr(a(2, 5), 32'd1);
      snap_at("per_v3", p + 23, 2, 32'd3);
      snap_at("per_v2_tick", p + 30, 2, 32'd2);
      snap_at("per_v1", p + 34, 2, 32'd1);
      snap_at("per_v0", p + 38, 2, 32'd0);
      snap_at("per_v3b", p + 43, 2, 32'd3);
      rd("per_pend2", a(2, 5), 32'd1);
      wr(a(2, 5), 32'd1);
      wait_to(p + 54); check("per_irq2_pre", 32'(irq_o), 32'h0);
      wait_to(p + 55); check("per_irq2", 32'(irq_o), 32'h4);
      wr(a(2, 2), 32'h0);
      wr(a(2, 5), 32'd1);

      // chain: ch1 ticks on ch0 zero events
      wr(a(0, 0), 32'd9);
      wr(a(0, 1), 32'd9);
      wr(a(1, 0), 32'd4);
      wr(a(1, 1), 32'd4);
      wr(a(1, 2), 32'h7);
      wr(a(0, 2), 32'h1);
      p = cyc_n;
      snap_at("chn_hold4", p + 8, 1, 32'd4);
      snap_at("chn_v3", p + 14, 1, 32'd3);
      wait_to(p + 38); check("chn_irq_pre", 32'(irq_o), 32'h0);
      wait_to(p + 39); check("chn_irq", 32'(irq_o), 32'h2);
      wr(a(1, 5), 32'd1);
      wait_to(p + 88); check("chn_irq2_pre", 32'(irq_o), 32'h0);
      wait_to(p + 89); check("chn_irq2", 32'(irq_o), 32'h2);
      wr(a(0, 2), 32'h0);
      wr(a(1, 2), 32'h0);
      wr(a(0, 5), 32'd1);
      wr(a(1, 5), 32'd1);

      // W1C racing the zero event on ch3: set wins
      wr(a(3, 0), 32'd5);
      wr(a(3, 1), 32'd0);
      wr(a(3, 2), 32'h1);
      p = cyc_n;
      wr_at(p + 5, a(3, 5), 32'd1);
      rd("race_pend", a(3, 5), 32'd1);
      wr(a(3, 5), 32'd1);
      rd("race_clr", a(3, 5), 32'd0);
      wr(a(3, 2), 32'h0);

      // bus edges
      wr(a(1, 0), 32'hFFFF_1234);
      rd("trunc", a(1, 0), 32'h0000_1234);
      wr(a(1, 0), 32'h5555_55AB, 4'b0001);
      rd("sel_b0", a(1, 0), 32'h0000_12AB);
      wr(a(1, 0), 32'h0000_CD00, 4'b0010);
      rd("sel_b1", a(1, 0), 32'h0000_CDAB);
      wr(a(1, 2), 32'hFFFF_FFF8);
      rd("ctrl_mask", a(1, 2), 32'h0000_FF00);
      wr(a(1, 2), 32'h0);
      wr(a(4, 0), 32'h1234);
      rd("ch_oob", a(4, 0), 32'd0);
      wr(a(0, 6), 32'h1234);
      rd("reg_unmap", a(0, 6), 32'd0);

      // async reset in the middle of a bus cycle
      wr(a(2, 0), 32'd2);
      wr(a(2, 2), 32'h3);
      repeat (6) @(posedge core_clk);
      #1 check("pre_rst_irq", 32'(irq_o), 32'h4);
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = a(2, 0);
      @(posedge core_clk); #1;
      check("mid_ack_hi", 32'(wb.ack), 32'd1);
      core_rstn = 1'b0;
      #1;
      check("mid_ack_drop", 32'(wb.ack), 32'd0);
      check("mid_irq", 32'(irq_o), 32'h0);
      wb.cyc = 1'b0; wb.stb = 1'b0;
      repeat (2) @(posedge core_clk);
      #1 core_rstn = 1'b1;
      rd("post_load2", a(2, 0), 32'd0);
      rd("post_ctrl2", a(2, 2), 32'd0);
      rd("post_stat2", a(2, 5), 32'd0);
      rd("post_load1", a(1, 0), 32'd0);
      check("post_irq", 32'(irq_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
